iopmp_seq_checker: RTL and testbench

Multi-entry IOPMP checker for the IOMMU page-table-walker and translation paths.
- Checks one access (address + byte length + read/write type) against NR_ENTRIES PMP entries, ENTRIES_PER_CYCLE entries per clock.
- Entries support OFF, TOR, NA4 and NAPOT modes. Lowest-index match has priority. Partial overlaps are denied.
- Valid/ready request and response handshakes; sits between the PTW memory-request port and the AXI master.

---
 rtl/iopmp_pkg.sv | 31 +++
 rtl/iopmp_entry_match.sv | 62 ++++++
 rtl/iopmp_seq_checker.sv | 164 ++++++++++++++++
 tb/tb_iopmp_seq_checker.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/iopmp_pkg.sv
// iopmp_pkg: shared types and group count for the sequential IOPMP checker
package iopmp_pkg;

    typedef struct packed {
        logic write;
        logic read;
    } acc_t;

    typedef struct packed {
        logic w;
        logic r;
    } perm_t;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_TOR   = 2'd1,
        MODE_NA4   = 2'd2,
        MODE_NAPOT = 2'd3
    } pmp_mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_RESP
    } state_e;

    localparam int unsigned DEF_NR_ENTRIES = 16;
    localparam int unsigned DEF_EPC        = 4;
    localparam int unsigned NR_GROUPS      = DEF_NR_ENTRIES / DEF_EPC;

endpackage

// File: rtl/iopmp_entry_match.sv
// iopmp_entry_match: combinational match of first/last byte against one PMP entry
module iopmp_entry_match
    import iopmp_pkg::*;
#(
    parameter int unsigned PLEN           = 56,
    parameter int unsigned PMP_LEN        = 54,
    parameter int unsigned PMPGranularity = 2
) (
    input  logic [PLEN-1:0]    first,
    input  logic [PLEN-1:0]    last,
    input  logic [PMP_LEN-1:0] addr_reg,
    input  logic [PMP_LEN-1:0] prev_reg,
    input  pmp_mode_e          mode,
    output logic               full,
    output logic               partial
);

    localparam int unsigned        TOR_CLR    = PMPGranularity > 2 ? PMPGranularity - 2 : 0;
    localparam int unsigned        NAPOT_SET  = PMPGranularity > 3 ? PMPGranularity - 3 : 0;
    localparam logic [PMP_LEN-1:0] TOR_KEEP   = {PMP_LEN{1'b1}} << TOR_CLR;
    localparam logic [PMP_LEN-1:0] NAPOT_ONES = ~({PMP_LEN{1'b1}} << NAPOT_SET);
    localparam bit                 NA4_OK     = PMPGranularity <= 2;

    logic [PMP_LEN-1:0] napot_reg;
    logic [PLEN-1:0]    lo, hi, base, mask;
    logic [7:0]         ones;
    logic               run;
    logic [1:0]         hit;

    assign napot_reg = addr_reg | NAPOT_ONES;
    assign lo        = PLEN'({prev_reg & TOR_KEEP, 2'b00});
    assign hi        = PLEN'({addr_reg & TOR_KEEP, 2'b00});
    assign base      = PLEN'({napot_reg, 2'b00});
    assign mask      = {PLEN{1'b1}} << (ones + 8'd3);

    // trailing-ones count of the NAPOT register sets the region size
    always_comb begin
        ones = '0;
        run  = 1'b1;
        for (int k = 0; k < PMP_LEN; k++) begin
            if (run && napot_reg[k]) ones = ones + 8'd1;
            else run = 1'b0;
        end
    end

    // same mode-dependent test applied to the first (j=0) and last (j=1) byte
    always_comb begin
        logic [PLEN-1:0] a;
        hit = '0;
        for (int j = 0; j < 2; j++) begin
            a      = j == 0 ? first : last;
            hit[j] = (mode == MODE_TOR)   ? (a >= lo && a < hi)
                   : (mode == MODE_NA4)   ? (NA4_OK && (a >> 2) == PLEN'(addr_reg))
                   : (mode == MODE_NAPOT) ? ((a & mask) == (base & mask))
                   : 1'b0;
        end
    end

    assign full    = &hit;
    assign partial = ^hit;

endmodule

// File: rtl/iopmp_seq_checker.sv
// iopmp_seq_checker: multi-cycle IOPMP check of one access, ENTRIES_PER_CYCLE entries per clock
module iopmp_seq_checker
    import iopmp_pkg::*;
#(
    parameter int unsigned PLEN              = 56,
    parameter int unsigned PMP_LEN           = 54,
    parameter int unsigned NR_ENTRIES        = 16,
    parameter int unsigned ENTRIES_PER_CYCLE = 4,
    parameter int unsigned PMPGranularity    = 2,
    localparam int unsigned IW = NR_ENTRIES > 1 ? $clog2(NR_ENTRIES) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [PLEN-1:0]               req_addr_i,
    input  logic [7:0]                    req_len_i,
    input  logic [1:0]                    req_acc_i,
    input  logic [NR_ENTRIES*PMP_LEN-1:0] cfg_addr_i,
    input  logic [NR_ENTRIES*2-1:0]       cfg_mode_i,
    input  logic [NR_ENTRIES*2-1:0]       cfg_perm_i,
    input  logic                          cfg_update_i,
    input  logic                          default_allow_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic                          rsp_allow_o,
    output logic                          rsp_hit_o,
    output logic [IW-1:0]                 rsp_idx_o
);

    localparam int unsigned NG = NR_ENTRIES / ENTRIES_PER_CYCLE;
    localparam int unsigned GW = NG > 1 ? $clog2(NG) : 1;

    state_e                 state;
    logic [PLEN-1:0]        addr_q, last_q;
    acc_t                   acc_q;
    logic [GW-1:0]          g_q;
    logic [PLEN:0]          last_n;

    logic [PMP_LEN-1:0]     ent_addr  [NR_ENTRIES];
    logic [PMP_LEN-1:0]     ent_prev  [NR_ENTRIES];
    pmp_mode_e              ent_mode  [NR_ENTRIES];
    perm_t                  ent_perm  [NR_ENTRIES];

    logic [IW-1:0]          lane_idx  [ENTRIES_PER_CYCLE];
    logic [PMP_LEN-1:0]     lane_reg  [ENTRIES_PER_CYCLE];
    logic [PMP_LEN-1:0]     lane_prev [ENTRIES_PER_CYCLE];
    pmp_mode_e              lane_mode [ENTRIES_PER_CYCLE];
    perm_t                  lane_perm [ENTRIES_PER_CYCLE];
    logic [ENTRIES_PER_CYCLE-1:0] lane_full, lane_part;

    logic                   dec_found, dec_allow;
    logic [IW-1:0]          dec_idx;

    // carry out of this sum flags an access that wraps past the top of memory
    assign last_n = {1'b0, req_addr_i} + {{(PLEN-7){1'b0}}, req_len_i};

    // unpack the flat config buses and steer the current group onto the lanes
    always_comb begin
        for (int i = 0; i < NR_ENTRIES; i++) begin
            ent_addr[i] = cfg_addr_i[i*PMP_LEN +: PMP_LEN];
            ent_mode[i] = pmp_mode_e'(cfg_mode_i[2*i +: 2]);
            ent_perm[i] = perm_t'(cfg_perm_i[2*i +: 2]);
        end
        ent_prev[0] = '0;
        for (int i = 1; i < NR_ENTRIES; i++) ent_prev[i] = ent_addr[i-1];
        for (int l = 0; l < ENTRIES_PER_CYCLE; l++) begin
            lane_idx[l]  = IW'(int'(g_q) * int'(ENTRIES_PER_CYCLE) + l);
            lane_reg[l]  = ent_addr[lane_idx[l]];
            lane_prev[l] = ent_prev[lane_idx[l]];
            lane_mode[l] = ent_mode[lane_idx[l]];
            lane_perm[l] = ent_perm[lane_idx[l]];
        end
    end

    for (genvar l = 0; l < ENTRIES_PER_CYCLE; l++) begin : g_lane
        iopmp_entry_match #(
            .PLEN           (PLEN),
            .PMP_LEN        (PMP_LEN),
            .PMPGranularity (PMPGranularity)
        ) u_match (
            .first    (addr_q),
            .last     (last_q),
            .addr_reg (lane_reg[l]),
            .prev_reg (lane_prev[l]),
            .mode     (lane_mode[l]),
            .full     (lane_full[l]),
            .partial  (lane_part[l])
        );
    end

    // lowest-index lane with any overlap decides; partial overlap always denies
    always_comb begin
        dec_found = 1'b0;
        dec_allow = 1'b0;
        dec_idx   = '0;
        for (int l = ENTRIES_PER_CYCLE - 1; l >= 0; l--) begin
            if (lane_full[l] || lane_part[l]) begin
                dec_found = 1'b1;
                dec_allow = lane_full[l] && |(2'(lane_perm[l]) & 2'(acc_q));
                dec_idx   = lane_idx[l];
            end
        end
    end

    // control FSM with registered handshake and verdict outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_allow_o <= 1'b0;
            rsp_hit_o   <= 1'b0;
            rsp_idx_o   <= '0;
            addr_q      <= '0;
            last_q      <= '0;
            acc_q       <= '0;
            g_q         <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_valid_i) begin
                    addr_q      <= req_addr_i;
                    last_q      <= last_n[PLEN-1:0];
                    acc_q       <= acc_t'(req_acc_i);
                    g_q         <= '0;
                    req_ready_o <= 1'b0;
                    if (last_n[PLEN]) begin
                        state       <= S_RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_allow_o <= 1'b0;
                        rsp_hit_o   <= 1'b0;
                        rsp_idx_o   <= '0;
                    end else begin
                        state <= S_SCAN;
                    end
                end
                S_SCAN: if (cfg_update_i) begin
                    g_q <= '0;
                end else if (dec_found) begin
                    state       <= S_RESP;
                    rsp_valid_o <= 1'b1;
                    rsp_allow_o <= dec_allow;
                    rsp_hit_o   <= 1'b1;
                    rsp_idx_o   <= dec_idx;
                end else if (g_q == GW'(NG - 1)) begin
                    state       <= S_RESP;
                    rsp_valid_o <= 1'b1;
                    rsp_allow_o <= default_allow_i;
                    rsp_hit_o   <= 1'b0;
                    rsp_idx_o   <= '0;
                end else begin
                    g_q <= g_q + 1'b1;
                end
                S_RESP: if (rsp_ready_i) begin
                    state       <= S_IDLE;
                    rsp_valid_o <= 1'b0;
                    req_ready_o <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iopmp_seq_checker.sv
// tb_iopmp_seq_checker: directed vector table plus multi-cycle corner sequences
module tb_iopmp_seq_checker;

    logic               clk = 1'b0;
    logic               rst_ni = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready_o;
    logic [55:0]        req_addr = '0;
    logic [7:0]         req_len = '0;
    logic [1:0]         req_acc = 2'b01;
    logic [16*54-1:0]   cfg_addr = '0;
    logic [31:0]        cfg_mode = '0;
    logic [31:0]        cfg_perm = '0;
    logic               cfg_update = 1'b0;
    logic               dflt = 1'b0;
    logic               rsp_valid_o;
    logic               rsp_ready = 1'b0;
    logic               rsp_allow_o;
    logic               rsp_hit_o;
    logic [3:0]         rsp_idx_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iopmp_seq_checker dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready_o),
        .req_addr_i      (req_addr),
        .req_len_i       (req_len),
        .req_acc_i       (req_acc),
        .cfg_addr_i      (cfg_addr),
        .cfg_mode_i      (cfg_mode),
        .cfg_perm_i      (cfg_perm),
        .cfg_update_i    (cfg_update),
        .default_allow_i (dflt),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready),
        .rsp_allow_o     (rsp_allow_o),
        .rsp_hit_o       (rsp_hit_o),
        .rsp_idx_o       (rsp_idx_o)
    );

    typedef struct {
        int         cfg;
        logic [55:0] addr;
        logic [7:0] len;
        logic [1:0] acc;
        logic       dflt;
        int         upd;
        logic       e_allow;
        logic       e_hit;
        logic [3:0] e_idx;
        int         e_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_entry(input int i, input logic [53:0] r, input logic [1:0] m, input logic [1:0] p);
        cfg_addr[i*54 +: 54] = r;
        cfg_mode[i*2 +: 2]   = m;
        cfg_perm[i*2 +: 2]   = p;
    endtask

    // modes: 0 OFF, 1 TOR, 2 NA4, 3 NAPOT; perms {W,R}
    task automatic set_cfg(input int id);
        cfg_addr = '0;
        cfg_mode = '0;
        cfg_perm = '0;
        case (id)
            0: set_entry(0, 54'h5FF, 2'd3, 2'b01);
            1: begin
                set_entry(1, 54'h800, 2'd0, 2'b01);
                set_entry(2, 54'hC00, 2'd1, 2'b01);
            end
            3: begin
                set_entry(5,  54'h400,  2'd2, 2'b11);
                set_entry(9,  54'h3FF,  2'd3, 2'b01);
                set_entry(13, 54'h3000, 2'd0, 2'b00);
                set_entry(14, 54'h4000, 2'd1, 2'b10);
            end
            default: ;
        endcase
    endtask

    // drive one request, count cycles from accept until rsp_valid_o, optional cfg pulse on cycle upd
    task automatic issue(input logic [55:0] a, input logic [7:0] l, input logic [1:0] acc,
                         input int upd, output int lat);
        @(negedge clk);
        chk("req_ready_idle", req_ready_o, 1);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        req_acc   = acc;
        @(posedge clk);
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            req_valid  = 1'b0;
            lat++;
            cfg_update = (lat == upd);
            if (rsp_valid_o) break;
        end
        cfg_update = 1'b0;
        if (!rsp_valid_o) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: rsp_valid_o still %0b after %0d cycles, required 1", rsp_valid_o, lat);
            lat = -1;
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_after_hs", rsp_valid_o, 0);
        chk("req_ready_after_hs", req_ready_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        vecs.push_back('{0, 56'h1F00,           8'hFF, 2'b01, 1'b0, -1, 1'b1, 1'b1, 4'd0,  2});
        vecs.push_back('{0, 56'h1FF8,           8'd15, 2'b01, 1'b0, -1, 1'b0, 1'b1, 4'd0,  2});
        vecs.push_back('{0, 56'h1F00,           8'd0,  2'b10, 1'b0, -1, 1'b0, 1'b1, 4'd0,  2});
        vecs.push_back('{0, 56'h0FFC,           8'd3,  2'b01, 1'b0, -1, 1'b0, 1'b0, 4'd0,  5});
        vecs.push_back('{1, 56'h2800,           8'd7,  2'b10, 1'b0, -1, 1'b0, 1'b1, 4'd2,  2});
        vecs.push_back('{1, 56'h2800,           8'd7,  2'b01, 1'b0, -1, 1'b1, 1'b1, 4'd2,  2});
        vecs.push_back('{1, 56'h1FFC,           8'd7,  2'b01, 1'b0, -1, 1'b0, 1'b1, 4'd2,  2});
        vecs.push_back('{2, 56'h9000,           8'd0,  2'b01, 1'b1, -1, 1'b1, 1'b0, 4'd0,  5});
        vecs.push_back('{2, 56'h9000,           8'd0,  2'b01, 1'b1,  3, 1'b1, 1'b0, 4'd0,  8});
        vecs.push_back('{3, 56'h1000,           8'd3,  2'b10, 1'b0, -1, 1'b1, 1'b1, 4'd5,  3});
        vecs.push_back('{3, 56'h1000,           8'd7,  2'b10, 1'b0, -1, 1'b0, 1'b1, 4'd5,  3});
        vecs.push_back('{3, 56'h1800,           8'd0,  2'b10, 1'b0, -1, 1'b0, 1'b1, 4'd9,  4});
        vecs.push_back('{3, 56'h1800,           8'hFF, 2'b01, 1'b0, -1, 1'b1, 1'b1, 4'd9,  4});
        vecs.push_back('{3, 56'hC000,           8'hFF, 2'b10, 1'b0, -1, 1'b1, 1'b1, 4'd14, 5});
        vecs.push_back('{3, 56'hFFF8,           8'd15, 2'b10, 1'b0, -1, 1'b0, 1'b1, 4'd14, 5});
        vecs.push_back('{3, 56'h20000,          8'd0,  2'b01, 1'b0, -1, 1'b0, 1'b0, 4'd0,  5});
        vecs.push_back('{3, 56'h8000,           8'd0,  2'b10, 1'b1, -1, 1'b1, 1'b0, 4'd0,  5});
        vecs.push_back('{0, 56'hFFFFFFFFFFFFF8, 8'd15, 2'b01, 1'b1, -1, 1'b0, 1'b0, 4'd0,  1});

        #1 rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", req_ready_o, 1);
        chk("reset_rsp_valid", rsp_valid_o, 0);
        chk("reset_allow", rsp_allow_o, 0);
        chk("reset_hit", rsp_hit_o, 0);
        chk("reset_idx", rsp_idx_o, 0);
        rst_ni = 1'b1;

        for (int v = 0; v < vecs.size(); v++) begin
            set_cfg(vecs[v].cfg);
            dflt = vecs[v].dflt;
            issue(vecs[v].addr, vecs[v].len, vecs[v].acc, vecs[v].upd, lat);
            chk($sformatf("v%0d_allow", v), rsp_allow_o, vecs[v].e_allow);
            chk($sformatf("v%0d_hit", v), rsp_hit_o, vecs[v].e_hit);
            chk($sformatf("v%0d_idx", v), rsp_idx_o, vecs[v].e_idx);
            chk($sformatf("v%0d_latency", v), lat, vecs[v].e_lat);
            release_rsp();
        end

        // wrap deny held with rsp_ready low: verdict stable, no new request taken
        set_cfg(0);
        dflt = 1'b1;
        issue(56'hFFFFFFFFFFFFF8, 8'd15, 2'b01, -1, lat);
        chk("wrap_latency", lat, 1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("wrap_hold_valid", rsp_valid_o, 1);
            chk("wrap_hold_req_ready", req_ready_o, 0);
            chk("wrap_hold_allow", rsp_allow_o, 0);
            chk("wrap_hold_hit", rsp_hit_o, 0);
        end
        release_rsp();

        // committed hit verdict ignores config changes and update pulses in RESP
        set_cfg(3);
        dflt = 1'b0;
        issue(56'h1800, 8'hFF, 2'b01, -1, lat);
        set_cfg(2);
        cfg_update = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("resp_hold_allow", rsp_allow_o, 1);
            chk("resp_hold_hit", rsp_hit_o, 1);
            chk("resp_hold_idx", rsp_idx_o, 9);
        end
        cfg_update = 1'b0;
        release_rsp();

        // reset asserted mid-SCAN aborts immediately
        set_cfg(2);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 56'h9000;
        req_len   = 8'd0;
        req_acc   = 2'b01;
        @(negedge clk);
        req_valid = 1'b0;
        chk("scan_req_ready", req_ready_o, 0);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        chk("abort_rsp_valid", rsp_valid_o, 0);
        chk("abort_req_ready", req_ready_o, 1);
        @(negedge clk);
        rst_ni = 1'b1;
        set_cfg(0);
        issue(56'h1F00, 8'hFF, 2'b01, -1, lat);
        chk("post_reset_allow", rsp_allow_o, 1);
        chk("post_reset_hit", rsp_hit_o, 1);
        chk("post_reset_idx", rsp_idx_o, 0);
        chk("post_reset_latency", lat, 2);
        release_rsp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
